// File: rtl/imem_loader_pkg.sv
// Shared sizing and state encoding for the instruction-memory loader.
// IMEM_CHECKSUM_EN adds the CHECK state that consumes a trailer byte.
package imem_loader_pkg;

    localparam int MEM_BYTES_DEF  = 512;
    localparam int ADDR_W_DEF     = 9;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
`ifdef IMEM_CHECKSUM_EN
        ST_CHECK = 2'd2,
`endif
        ST_FIN   = 2'd3
    } state_t;

    // Image is good when data bytes plus trailer sum to zero modulo 256.
    function automatic logic chk_pass(input logic [7:0] sum, input logic [7:0] trailer);
        logic [7:0] total;
        total = sum + trailer;
        return total == 8'h00;
    endfunction

endpackage

// File: rtl/imem_chksum.sv
// Running modulo-256 sum of the data bytes of one load; only built with IMEM_CHECKSUM_EN.
module imem_chksum (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] sum
);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sum <= 8'h00;
        end else if (clr) begin
            sum <= 8'h00;
        end else if (en) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams a big-endian byte image into instruction memory, holding the fetch via busy.
// Optional IMEM_CHECKSUM_EN: a trailer byte after the data must zero the byte sum.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        word_cnt,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // One extra bit so a full-memory byte count is representable.
    localparam int CNT_W = ADDR_W + 1;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  remaining;
    logic [31:0]       req_bytes;
    logic              req_fits;
    logic              accept;
    logic              last_byte;

    assign req_bytes = 32'(word_cnt) * 32'(BYTES_PER_WORD);
    assign req_fits  = req_bytes <= 32'(MEM_BYTES);
    assign accept    = in_valid && in_ready;
    assign last_byte = remaining == CNT_W'(1);

`ifdef IMEM_CHECKSUM_EN
    logic [7:0] sum;

    imem_chksum u_chksum (
        .clk  (clk),
        .rst  (rst),
        .clr  (state == ST_IDLE),
        .en   (accept && (state == ST_LOAD)),
        .data (in_data),
        .sum  (sum)
    );
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (word_cnt == 8'd0) begin
                            state <= ST_FIN;
                            busy  <= 1'b1;
                            done  <= 1'b1;
                        end else if (!req_fits) begin
                            err <= 1'b1;
                        end else begin
                            state     <= ST_LOAD;
                            remaining <= req_bytes[CNT_W-1:0];
                            addr      <= '0;
                            in_ready  <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= addr;
                        mem_wdata <= in_data;
                        addr      <= addr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (last_byte) begin
`ifdef IMEM_CHECKSUM_EN
                            // in_ready stays high to take the trailer byte.
                            state <= ST_CHECK;
`else
                            state    <= ST_FIN;
                            in_ready <= 1'b0;
                            done     <= 1'b1;
`endif
                        end
                    end
                end

`ifdef IMEM_CHECKSUM_EN
                ST_CHECK: begin
                    if (accept) begin
                        state    <= ST_FIN;
                        in_ready <= 1'b0;
                        done     <= 1'b1;
                        err      <= !chk_pass(sum, in_data);
                    end
                end
`endif

                ST_FIN: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal loads, stalls, size guard, empty load, reset abort.
// Trailer scenarios are compiled in when IMEM_CHECKSUM_EN is defined.
module tb_imem_loader;

    localparam int ADDR_W = 9;

    logic              clk;
    logic              rst;
    logic              start;
    logic [7:0]        word_cnt;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              busy;
    logic              done;
    logic              err;

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] wr_addr [2048];
    logic [7:0]        wr_data [2048];
    int                wcnt = 0;
    int                w0;

    logic [7:0] s1_bytes [4] = '{8'h24, 8'h01, 8'h00, 8'h01};
    logic [7:0] s6_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    imem_loader #(.MEM_BYTES(512), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .word_cnt  (word_cnt),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log taken at the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (mem_we === 1'b1 && wcnt < 2048) begin
            wr_addr[wcnt] = mem_addr;
            wr_data[wcnt] = mem_wdata;
            wcnt = wcnt + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called right after the last data byte was accepted.
    task automatic expect_done(input logic [7:0] sum, input string tag);
        in_valid = 1'b0;
`ifdef IMEM_CHECKSUM_EN
        chk({tag, "_chk_ready"}, 32'(in_ready), 1);
        chk({tag, "_chk_nodone"}, 32'(done), 0);
        in_valid = 1'b1;
        in_data  = 8'h00 - sum;
        tick();
        in_valid = 1'b0;
        chk({tag, "_trailer_nowrite"}, 32'(mem_we), 0);
`else
        chk({tag, "_last_we"}, 32'(mem_we), 1);
`endif
        chk({tag, "_done"}, 32'(done), 1);
        chk({tag, "_noerr"}, 32'(err), 0);
        chk({tag, "_busy_fin"}, 32'(busy), 1);
        chk({tag, "_ready_fin"}, 32'(in_ready), 0);
        tick();
        chk({tag, "_done_clr"}, 32'(done), 0);
        chk({tag, "_busy_clr"}, 32'(busy), 0);
        chk({tag, "_we_clr"}, 32'(mem_we), 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; word_cnt = 8'd0; in_valid = 1'b0; in_data = 8'h00;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        rst = 1'b1;
        tick();
        chk("idle_in_ready", 32'(in_ready), 0);
        chk("idle_busy", 32'(busy), 0);

        // One word, back-to-back bytes, one-cycle write latency.
        w0 = wcnt;
        start = 1'b1; word_cnt = 8'd1;
        tick();
        start = 1'b0;
        chk("s1_ready", 32'(in_ready), 1);
        chk("s1_busy", 32'(busy), 1);
        chk("s1_no_we", 32'(mem_we), 0);
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = s1_bytes[k];
            tick();
            chk($sformatf("s1_we%0d", k), 32'(mem_we), 1);
            chk($sformatf("s1_addr%0d", k), 32'(mem_addr), k);
            chk($sformatf("s1_data%0d", k), 32'(mem_wdata), 32'(s1_bytes[k]));
            if (k < 3) chk($sformatf("s1_nodone%0d", k), 32'(done), 0);
        end
        expect_done(8'h26, "s1");
        chk("s1_wcount", wcnt - w0, 4);

        // Two words with a 3-cycle source gap mid-word; start during the load is ignored.
        w0 = wcnt;
        start = 1'b1; word_cnt = 8'd2;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (k == 3) begin
                in_valid = 1'b0;
                tick();
                start = 1'b1; word_cnt = 8'd0;
                tick();
                start = 1'b0;
                chk("s2_gap_we", 32'(mem_we), 0);
                chk("s2_gap_done", 32'(done), 0);
                tick();
                chk("s2_gap_we2", 32'(mem_we), 0);
                chk("s2_gap_ready", 32'(in_ready), 1);
            end
            in_valid = 1'b1; in_data = 8'(8'hA0 + k);
            tick();
        end
        expect_done(8'h1C, "s2");
        chk("s2_wcount", wcnt - w0, 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("s2_addr%0d", k), 32'(wr_addr[w0 + k]), k);
            chk($sformatf("s2_data%0d", k), 32'(wr_data[w0 + k]), 32'h0A0 + k);
        end

        // Oversize request: err pulse, stay idle, no writes.
        w0 = wcnt;
        start = 1'b1; word_cnt = 8'd129;
        tick();
        start = 1'b0;
        chk("s3_err", 32'(err), 1);
        chk("s3_ready", 32'(in_ready), 0);
        chk("s3_busy", 32'(busy), 0);
        chk("s3_we", 32'(mem_we), 0);
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        in_valid = 1'b0;
        chk("s3_err_clr", 32'(err), 0);
        chk("s3_ready2", 32'(in_ready), 0);
        tick();
        chk("s3_wcount", wcnt - w0, 0);

        // Empty load: done with busy for one cycle, no writes.
        w0 = wcnt;
        start = 1'b1; word_cnt = 8'd0;
        tick();
        start = 1'b0;
        chk("s4_done", 32'(done), 1);
        chk("s4_busy", 32'(busy), 1);
        chk("s4_ready", 32'(in_ready), 0);
        chk("s4_err", 32'(err), 0);
        tick();
        chk("s4_done_clr", 32'(done), 0);
        chk("s4_busy_clr", 32'(busy), 0);
        chk("s4_wcount", wcnt - w0, 0);

        // Largest legal image fills memory exactly, last address 511.
        w0 = wcnt;
        start = 1'b1; word_cnt = 8'd128;
        tick();
        start = 1'b0;
        chk("s5_ready", 32'(in_ready), 1);
        chk("s5_err", 32'(err), 0);
        for (int k = 0; k < 512; k++) begin
            in_valid = 1'b1; in_data = 8'(k);
            tick();
        end
        expect_done(8'h00, "s5");
        chk("s5_wcount", wcnt - w0, 512);
        chk("s5_addr0", 32'(wr_addr[w0]), 0);
        chk("s5_addr255", 32'(wr_addr[w0 + 255]), 255);
        chk("s5_data255", 32'(wr_data[w0 + 255]), 32'hFF);
        chk("s5_addr511", 32'(wr_addr[w0 + 511]), 511);
        chk("s5_data511", 32'(wr_data[w0 + 511]), 32'hFF);

        // Reset after 5 accepted bytes of a 4-word load, then a fresh load.
        w0 = wcnt;
        start = 1'b1; word_cnt = 8'd4;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 8'(8'h50 + k);
            tick();
        end
        chk("s6_we5", 32'(mem_we), 1);
        chk("s6_addr5", 32'(mem_addr), 4);
        rst = 1'b0;
        tick();
        chk("s6_rst_ready", 32'(in_ready), 0);
        chk("s6_rst_we", 32'(mem_we), 0);
        chk("s6_rst_busy", 32'(busy), 0);
        chk("s6_rst_done", 32'(done), 0);
        chk("s6_rst_err", 32'(err), 0);
        chk("s6_rst_addr", 32'(mem_addr), 0);
        chk("s6_rst_wdata", 32'(mem_wdata), 0);
        rst = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("s6_post_ready", 32'(in_ready), 0);
        chk("s6_post_done", 32'(done), 0);
        tick();
        chk("s6_wcount", wcnt - w0, 5);
        w0 = wcnt;
        start = 1'b1; word_cnt = 8'd1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = s6_bytes[k];
            tick();
            if (k == 0) begin
                chk("s6_reload_addr0", 32'(mem_addr), 0);
                chk("s6_reload_data0", 32'(mem_wdata), 32'h11);
            end
        end
        expect_done(8'hAA, "s6");
        chk("s6_reload_wcount", wcnt - w0, 4);
        chk("s6_reload_last", 32'(wr_addr[w0 + 3]), 3);

`ifdef IMEM_CHECKSUM_EN
        // Good and bad trailers for bytes 01 02 03 04.
        for (int t = 0; t < 2; t++) begin
            start = 1'b1; word_cnt = 8'd1;
            tick();
            start = 1'b0;
            for (int k = 0; k < 4; k++) begin
                in_valid = 1'b1; in_data = 8'(k + 1);
                tick();
            end
            chk($sformatf("c%0d_ready", t), 32'(in_ready), 1);
            chk($sformatf("c%0d_nodone", t), 32'(done), 0);
            in_data = (t == 0) ? 8'hF6 : 8'hF5;
            tick();
            in_valid = 1'b0;
            chk($sformatf("c%0d_done", t), 32'(done), 1);
            chk($sformatf("c%0d_err", t), 32'(err), t);
            chk($sformatf("c%0d_nowrite", t), 32'(mem_we), 0);
            tick();
            chk($sformatf("c%0d_err_clr", t), 32'(err), 0);
            chk($sformatf("c%0d_busy_clr", t), 32'(busy), 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 512, the byte capacity of the target instruction memory.
REQ-002 SHALL have parameter ADDR_W, default 9, the byte-address width (log2 MEM_BYTES).
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 SHALL have port word_cnt  input  8  the number of 32-bit words to load, sampled on start.
REQ-007 SHALL have port in_valid  input  1  the byte-stream source has a byte.
REQ-008 SHALL have port in_data  input  8  the stream byte.
REQ-009 SHALL have port in_ready  output  1  the loader accepts a byte this cycle.
REQ-010 SHALL have port mem_we  output  1  the byte write strobe to instruction memory.
REQ-011 SHALL have port mem_addr  output  ADDR_W  the byte write address.
REQ-012 SHALL have port mem_wdata  output  8  the byte write data.
REQ-013 SHALL have port busy  output  1  a load is in progress; the pipeline holds its fetch while set.
REQ-014 SHALL have port done  output  1  a one-cycle pulse at load completion.
REQ-015 SHALL have port err  output  1  a one-cycle pulse on a rejected start or a failed check.

Function
REQ-016 SHALL use states IDLE, LOAD, CHECK (macro only) and FIN.
REQ-017 IDLE: in_ready=0 and busy=0; on start with 0<word_cnt*4<=MEM_BYTES, latch remaining=word_cnt*4, zero the address, and go to LOAD.
REQ-018 IDLE: start with word_cnt==0 SHALL go to FIN with no writes.
REQ-019 IDLE: start with word_cnt*4>MEM_BYTES SHALL pulse err the next cycle and remain in IDLE.
REQ-020 LOAD: in_ready=1 and busy=1; a byte is accepted only when in_valid&&in_ready.
REQ-021 An accepted byte SHALL appear on mem_we/mem_addr/mem_wdata exactly one cycle later (registered).
REQ-022 Bytes SHALL go to ascending addresses starting at 0, so word n occupies 4n..4n+3 with its MSB at 4n, matching the big-endian fetch.
REQ-023 The address SHALL never wrap; the guard in REQ-019 guarantees the last address is <=MEM_BYTES-1.
REQ-024 Gaps in in_valid SHALL only stall; they never advance the address or cause a write.
REQ-025 When the final byte is accepted, LOAD SHALL transition to FIN, or to CHECK with the macro.
REQ-026 FIN: done=1 for exactly one cycle, busy=1, then IDLE.
REQ-027 busy SHALL stay high through the cycle of the last mem_we.
REQ-028 start while not in IDLE SHALL be ignored.
REQ-029 mem_we SHALL be 0 in every cycle not covered by REQ-021.

Reset
REQ-030 On rst==0 at a clock edge: state=IDLE; in_ready, mem_we, busy, done and err=0; mem_addr=0, mem_wdata=0, counters=0, checksum=0.
REQ-031 Reset mid-LOAD SHALL abandon the load immediately, with no further writes and no done.

Configuration
REQ-032 With IMEM_CHECKSUM_EN defined: after the last data byte, in CHECK, in_ready=1 and one trailer byte is accepted; if (sum of data bytes + trailer) mod 256 == 0, done pulses; otherwise done and err pulse in the same cycle; the trailer is never written.
REQ-033 Without IMEM_CHECKSUM_EN: there is no CHECK state and no checksum register, and err pulses only per REQ-019.

Structure
REQ-034 A shared package SHALL hold the state enum, MEM_BYTES/ADDR_W defaults and BYTES_PER_WORD=4.
REQ-035 A checksum accumulator sub-module, imem_chksum, SHALL exist only under the macro; all other logic stays in one module.

Verification
REQ-036 Scenario: start, word_cnt=1, bytes 24 01 00 01 back-to-back -> writes at addresses 0..3 with those bytes, each one cycle after acceptance; done one cycle after the last accept.
REQ-037 Scenario: word_cnt=2 with in_valid low for 3 cycles mid-word -> 8 writes at addresses 0..7, no gaps in addresses, no extra writes.
REQ-038 Scenario: word_cnt=129 (MEM_BYTES=512) -> err pulse, in_ready stays 0, no mem_we.
REQ-039 Scenario: word_cnt=0 -> done pulse, no writes, busy high for 1 cycle.
REQ-040 Scenario: rst=0 after 5 accepted bytes of a 4-word load -> all outputs at reset values next cycle, and a following start reloads from address 0.
REQ-041 Scenario (macro): bytes 01 02 03 04 with trailer F6 -> done with no err; with trailer F5 -> done and err together.
